cordic_vectoring: RTL and testbench

Iterative CORDIC engine in vectoring mode: accepts a Cartesian vector (x, y) and returns its gain-scaled magnitude and its angle atan2(y, x). This is the inverse direction of the rotation-mode CORDIC pipeline, which turns an angle into a vector. The block sits downstream of the I/Q sample path as the polar converter. It performs one micro-rotation per clock and uses a valid/ready handshake on both sides.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_vector_step.sv | 50 +++++
 rtl/cordic_vectoring.sv | 169 ++++++++++++++++
 tb/tb_cordic_vectoring.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the vectoring-mode CORDIC engine:
//   - state_t         : controller state encoding (IDLE / ITER / DONE)
//   - ATAN_Q15        : atan(2^-i)/pi * 2^15, rounded, for i = 0..14
//   - CORDIC_GAIN_Q15 : accumulated CORDIC gain K (~1.64676) in Q1.15
//   - atan_lut()      : returns ATAN[i] rescaled to a given fractional width
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ATAN_FRAC = 15;
  localparam int ATAN_LEN  = 15;

  // Binary-angle table: 2^15 corresponds to pi.
  localparam int ATAN_Q15 [ATAN_LEN] = '{
    8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1
  };

  // K = prod_{i=0..14} sqrt(1 + 2^-2i) ~= 1.646760, scaled by 2^15.
  localparam int CORDIC_GAIN_Q15 = 53961;

  // The table is held at 15 fractional bits; narrower angle words get a
  // round-half-up rescale, wider ones a plain left shift.
  function automatic int atan_lut(input int idx, input int n_frac);
    int v;
    v = 0;
    if (idx >= 0 && idx < ATAN_LEN) v = ATAN_Q15[idx];
    if (n_frac < ATAN_FRAC)
      v = (v + (1 << (ATAN_FRAC - n_frac - 1))) >>> (ATAN_FRAC - n_frac);
    else if (n_frac > ATAN_FRAC)
      v = v << (n_frac - ATAN_FRAC);
    return v;
  endfunction

endpackage

// File: rtl/cordic_vector_step.sv
// -----------------------------------------------------------------------------
// cordic_vector_step
// One combinational vectoring-mode micro-rotation. Drives y toward zero and
// accumulates the rotated angle.
// Ports:
//   i_x, i_y   signed N_FRAC+3 current vector (Q3.N_FRAC)
//   i_z        signed N_FRAC+1 current angle accumulator (binary angle)
//   i_shift    iteration index i (shift amount)
//   i_atan     ATAN[i] for this iteration
//   o_x, o_y   next vector
//   o_z        next angle (wraps modulo 2^(N_FRAC+1))
// -----------------------------------------------------------------------------
module cordic_vector_step #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4
) (
  input  logic signed [N_FRAC+2:0]       i_x,
  input  logic signed [N_FRAC+2:0]       i_y,
  input  logic signed [N_FRAC:0]         i_z,
  input  logic        [BW_SHIFT_VALUE-1:0] i_shift,
  input  logic signed [N_FRAC:0]         i_atan,
  output logic signed [N_FRAC+2:0]       o_x,
  output logic signed [N_FRAC+2:0]       o_y,
  output logic signed [N_FRAC:0]         o_z
);

  logic signed [N_FRAC+2:0] w_x_sh;
  logic signed [N_FRAC+2:0] w_y_sh;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise;
  // both updates use the incoming (old) x/y.
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_y[N_FRAC+2]) begin
      o_x = i_x + w_y_sh;
      o_y = i_y - w_x_sh;
      o_z = i_z + i_atan;
    end else begin
      o_x = i_x - w_y_sh;
      o_y = i_y + w_x_sh;
      o_z = i_z - i_atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
// Iterative vectoring-mode CORDIC: converts (x, y) to K*|v| and atan2(y, x),
// one micro-rotation per clock, valid/ready on both sides.
// Ports:
//   clk_i        clock (rising edge)
//   rst_i        asynchronous active-low reset
//   in_valid_i   x_i/y_i valid
//   in_ready_o   high in IDLE; vector accepted on in_valid_i && in_ready_o
//   x_i, y_i     signed Q1.N_FRAC input vector
//   out_valid_o  result valid (DONE)
//   out_ready_i  downstream accepts result
//   magnitude_o  unsigned Q3.N_FRAC, K*sqrt(x^2+y^2), gain not compensated
//   angle_o      signed binary angle, 2^N_FRAC = pi
// -----------------------------------------------------------------------------
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int N_FRAC         = 15,
  parameter int N_ITER         = 15,
  parameter int BW_SHIFT_VALUE = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [N_FRAC:0] x_i,
  input  logic signed [N_FRAC:0] y_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N_FRAC+2:0]      magnitude_o,
  output logic signed [N_FRAC:0] angle_o
);

  localparam int DW = N_FRAC + 1;
  localparam int XW = N_FRAC + 3;
  localparam logic [BW_SHIFT_VALUE-1:0] LAST_ITER = BW_SHIFT_VALUE'(N_ITER - 1);
  localparam logic signed [DW-1:0] HALF_PI = DW'(1 << (N_FRAC - 1));

  state_t r_state;
  state_t w_state_nxt;

  logic [BW_SHIFT_VALUE-1:0] r_iter;
  logic signed [XW-1:0]      r_x;
  logic signed [XW-1:0]      r_y;
  logic signed [DW-1:0]      r_z;
  logic [XW-1:0]             r_mag;
  logic signed [DW-1:0]      r_ang;

  logic                      w_in_ready;
  logic                      w_out_valid;
  logic                      w_last;
  logic signed [XW-1:0]      w_x_ext;
  logic signed [XW-1:0]      w_y_ext;
  logic signed [XW-1:0]      w_x_ld;
  logic signed [XW-1:0]      w_y_ld;
  logic signed [DW-1:0]      w_z_ld;
  logic signed [DW-1:0]      w_atan;
  logic signed [XW-1:0]      w_x_nxt;
  logic signed [XW-1:0]      w_y_nxt;
  logic signed [DW-1:0]      w_z_nxt;

  assign w_last = (r_iter == LAST_ITER);
  assign w_atan = DW'(atan_lut(int'(r_iter), N_FRAC));

  // Inputs are widened before any negation so that -(-1.0) is representable.
  assign w_x_ext = XW'(x_i);
  assign w_y_ext = XW'(y_i);

  // Pre-rotation by +/-pi/2 moves left-half-plane vectors into x >= 0,
  // where the micro-rotations converge.
  always_comb begin
    w_x_ld = w_x_ext;
    w_y_ld = w_y_ext;
    w_z_ld = '0;
    if (x_i[N_FRAC]) begin
      if (!y_i[N_FRAC]) begin
        w_x_ld = w_y_ext;
        w_y_ld = -w_x_ext;
        w_z_ld = HALF_PI;
      end else begin
        w_x_ld = -w_y_ext;
        w_y_ld = w_x_ext;
        w_z_ld = -HALF_PI;
      end
    end
  end

  cordic_vector_step #(
    .N_FRAC         (N_FRAC),
    .BW_SHIFT_VALUE (BW_SHIFT_VALUE)
  ) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (w_atan),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid_i) w_state_nxt = ST_ITER;
      end
      ST_ITER: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_iter <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_mag  <= '0;
      r_ang  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_x    <= w_x_ld;
            r_y    <= w_y_ld;
            r_z    <= w_z_ld;
            r_iter <= '0;
          end
        end
        ST_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (w_last) begin
            // Final x is the non-negative gain-scaled magnitude.
            r_mag  <= $unsigned(w_x_nxt);
            r_ang  <= w_z_nxt;
            r_iter <= '0;
          end else begin
            r_iter <= r_iter + BW_SHIFT_VALUE'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign magnitude_o = r_mag;
  assign angle_o     = r_ang;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

  localparam int N_FRAC = 15;
  localparam int N_ITER = 15;
  localparam int BW     = 4;
  localparam int MAG_TOL = 8;
  localparam int ANG_TOL = 4;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic signed [15:0] x_i;
  logic signed [15:0] y_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [17:0]        magnitude_o;
  logic signed [15:0] angle_o;

  int  errors = 0;
  int  checks = 0;
  real K;

  cordic_vectoring #(
    .N_FRAC         (N_FRAC),
    .N_ITER         (N_ITER),
    .BW_SHIFT_VALUE (BW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .magnitude_o (magnitude_o),
    .angle_o     (angle_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp,
                           input int tol, input bit wrap16);
    int d;
    bit ok;
    d = obs - exp;
    if (wrap16) begin
      d = d & 65535;
      if (d >= 32768) d = d - 65536;
    end
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Reference: ideal polar conversion with the uncompensated gain.
  function automatic int ref_mag(input int x, input int y);
    real rx, ry;
    rx = x;
    ry = y;
    return int'(K * $sqrt(rx * rx + ry * ry));
  endfunction

  function automatic int ref_ang(input int x, input int y);
    real rx, ry;
    rx = x;
    ry = y;
    return int'($atan2(ry, rx) / 3.14159265358979 * 32768.0);
  endfunction

  // Presents a vector for exactly one cycle; returns just after the accepting edge.
  task automatic send(input string tag, input int x, input int y);
    check_eq({tag, " in_ready"}, longint'(in_ready_o), 1);
    x_i = 16'(x);
    y_i = 16'(y);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  // out_valid_o should appear N_ITER edges after the accepting edge
  // (the 16th edge when the accepting edge itself is counted).
  task automatic wait_done(input string tag);
    int edges;
    edges = 0;
    while (!out_valid_o && edges < 100) begin
      tick();
      edges++;
    end
    check_eq({tag, " latency"}, edges, N_ITER);
  endtask

  task automatic release_result(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check_eq({tag, " out_valid after handshake"}, longint'(out_valid_o), 0);
    check_eq({tag, " in_ready after handshake"}, longint'(in_ready_o), 1);
  endtask

  task automatic run_vec(input string tag, input int x, input int y,
                         input int exp_mag, input int exp_ang);
    send(tag, x, y);
    wait_done(tag);
    check_tol({tag, " magnitude"}, int'(magnitude_o), exp_mag, MAG_TOL, 1'b0);
    check_tol({tag, " angle"}, int'(angle_o), exp_ang, ANG_TOL, 1'b1);
    release_result(tag);
  endtask

  initial begin
    real p;
    int  rx, ry;
    int  hold_mag, hold_ang;
    int  acc_cnt, acc_t0, acc_t1, acc_t2;

    K = 1.0;
    p = 1.0;
    for (int i = 0; i < N_ITER; i++) begin
      K = K * $sqrt(1.0 + p);
      p = p / 4.0;
    end

    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    x_i         = '0;
    y_i         = '0;
    tick();
    tick();
    check_eq("reset out_valid", longint'(out_valid_o), 0);
    check_eq("reset in_ready", longint'(in_ready_o), 1);
    check_eq("reset magnitude", longint'(magnitude_o), 0);
    check_eq("reset angle", longint'(angle_o), 0);
    #3 rst_i = 1'b1;

    // Directed vectors with known results.
    run_vec("pos_x",   16384,      0, 26981,      0);
    run_vec("pos_y",       0,  16384, 26981,  16384);
    run_vec("q3_diag", -16384, -16384, 38158, -24576);
    run_vec("neg_one", -32768,      0, 53963,  32768);
    run_vec("q2",     -20000,  12000, ref_mag(-20000, 12000), ref_ang(-20000, 12000));

    send("zero", 0, 0);
    wait_done("zero");
    check_eq("zero magnitude", longint'(magnitude_o), 0);
    release_result("zero");

    // Result held while downstream stalls; new input ignored in DONE.
    send("stall", 12000, -9000);
    wait_done("stall");
    hold_mag = int'(magnitude_o);
    hold_ang = int'(angle_o);
    check_tol("stall magnitude", hold_mag, ref_mag(12000, -9000), MAG_TOL, 1'b0);
    check_tol("stall angle", hold_ang, ref_ang(12000, -9000), ANG_TOL, 1'b1);
    x_i = 16'(-30000);
    y_i = 16'(5000);
    in_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("stall out_valid", longint'(out_valid_o), 1);
      check_eq("stall in_ready", longint'(in_ready_o), 0);
      check_eq("stall magnitude hold", longint'(magnitude_o), longint'(hold_mag));
      check_eq("stall angle hold", longint'(angle_o), longint'(hold_ang));
    end
    in_valid_i = 1'b0;
    release_result("stall");

    // in_valid pulses while iterating must not disturb the running vector.
    send("iter_pulse", 0, 16384);
    for (int c = 0; c < N_ITER; c++) begin
      in_valid_i = c[0];
      x_i = 16'(-16384);
      y_i = 16'(-16384);
      tick();
    end
    in_valid_i = 1'b0;
    check_eq("iter_pulse out_valid", longint'(out_valid_o), 1);
    check_tol("iter_pulse magnitude", int'(magnitude_o), 26981, MAG_TOL, 1'b0);
    check_tol("iter_pulse angle", int'(angle_o), 16384, ANG_TOL, 1'b1);
    release_result("iter_pulse");

    // Back-to-back: both handshakes held high, measure accept spacing.
    x_i = 16'(16384);
    y_i = 16'(0);
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    acc_cnt = 0;
    acc_t0 = 0;
    acc_t1 = 0;
    acc_t2 = 0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready_o) begin
        if (acc_cnt == 0) acc_t0 = c;
        else if (acc_cnt == 1) acc_t1 = c;
        else if (acc_cnt == 2) acc_t2 = c;
        acc_cnt++;
      end
      if (out_valid_o)
        check_tol("b2b magnitude", int'(magnitude_o), 26981, MAG_TOL, 1'b0);
      tick();
    end
    in_valid_i = 1'b0;
    check_eq("b2b accept count", acc_cnt >= 3 ? 1 : 0, 1);
    check_eq("b2b spacing 1", acc_t1 - acc_t0, N_ITER + 2);
    check_eq("b2b spacing 2", acc_t2 - acc_t1, N_ITER + 2);
    for (int c = 0; c < 20; c++) tick();
    out_ready_i = 1'b0;
    check_eq("b2b drained in_ready", longint'(in_ready_o), 1);

    // Leave a non-zero result, then reset in the middle of iteration 7.
    run_vec("pre_rst", -16384, -16384, 38158, -24576);
    send("mid_rst", 16384, 0);
    for (int c = 0; c < 7; c++) tick();
    rst_i = 1'b0;
    #1;
    check_eq("mid_rst out_valid", longint'(out_valid_o), 0);
    check_eq("mid_rst magnitude", longint'(magnitude_o), 0);
    check_eq("mid_rst angle", longint'(angle_o), 0);
    check_eq("mid_rst in_ready", longint'(in_ready_o), 1);
    #3 rst_i = 1'b1;
    run_vec("post_rst", 16384, 0, 26981, 0);

    // Randomized vectors against the ideal polar model.
    for (int n = 0; n < 10; n++) begin
      real r2;
      do begin
        rx = int'($urandom_range(65535, 0)) - 32768;
        ry = int'($urandom_range(65535, 0)) - 32768;
        r2 = real'(rx) * real'(rx) + real'(ry) * real'(ry);
      end while (r2 < 268435456.0);
      run_vec($sformatf("rand%0d(%0d,%0d)", n, rx, ry), rx, ry,
              ref_mag(rx, ry), ref_ang(rx, ry));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
